reset_seq: RTL and testbench

- Downstream consumer of the board-level reset-delay stage's RESET_N.
- Releases the subsystem resets in a fixed order: SDRAM controller first, then video, then CPU core.
- Waits for SDRAM init completion before releasing video and CPU.
- Handles CPU-initiated soft reset, which re-resets only the CPU.

---
 rtl/reset_seq_if.sv | 54 +++++
 rtl/reset_seq.sv | 243 ++++++++++++++++++++++++
 tb/tb_reset_seq.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/reset_seq_if.sv
// ---------------------------------------------------------------------------
// reset_seq_if
//
// Purpose:
//   Bundles the reset sequencer's subsystem-facing signals so the sequencer
//   and whatever drives/observes it share a single connection point.
//
// Signal summary:
//   sdramInitDone  SDRAM controller init complete (level, asynchronous)
//   softResetReq   CPU soft reset request (synchronous to clk, level)
//   sdramResetN    SDRAM controller reset, active-low
//   videoResetN    video subsystem reset, active-low
//   cpuResetN      CPU core reset, active-low
//   sysReady       high only while the sequencer sits in RUN
//   seqErr         SDRAM init timeout flag (0 unless timeout support built)
//
// Modports:
//   slave   the reset sequencer itself (consumes requests, drives resets)
//   master  the surrounding system (drives requests, observes resets)
// ---------------------------------------------------------------------------
interface reset_seq_if;

  logic sdramInitDone;
  logic softResetReq;
  logic sdramResetN;
  logic videoResetN;
  logic cpuResetN;
  logic sysReady;
  logic seqErr;

  // The sequencer listens to the two request/status lines and owns every
  // reset output.
  modport slave (
    input  sdramInitDone,
    input  softResetReq,
    output sdramResetN,
    output videoResetN,
    output cpuResetN,
    output sysReady,
    output seqErr
  );

  // The surrounding system sees the mirror image of the sequencer.
  modport master (
    output sdramInitDone,
    output softResetReq,
    input  sdramResetN,
    input  videoResetN,
    input  cpuResetN,
    input  sysReady,
    input  seqErr
  );

endinterface : reset_seq_if

// File: rtl/reset_seq.sv
// ---------------------------------------------------------------------------
// reset_seq
//
// Purpose:
//   Sits downstream of the board-level reset-delay stage and releases the
//   subsystem resets in a fixed order: SDRAM controller, then video, then
//   CPU core.  Video and CPU are only released once the SDRAM controller
//   reports init complete.  While running, the CPU may request a soft reset
//   which re-resets only the CPU core for a fixed hold time.
//
// Parameters:
//   STAGE_DLY  clk cycles between successive stage releases (>= 1)
//   SOFT_HOLD  clk cycles the CPU reset is held low on a soft reset (>= 1)
//   SDRAM_TMO  clk cycles to wait for SDRAM init before forcing the
//              sequence on (only meaningful with RESET_SEQ_TMO_EN)
//
// Ports:
//   clk      system clock (50 MHz)
//   rst_n    asynchronous active-low reset from the reset-delay stage
//   seqBus   reset_seq_if.slave: sdramInitDone / softResetReq in,
//            sdramResetN / videoResetN / cpuResetN / sysReady / seqErr out
//
// Build option:
//   RESET_SEQ_TMO_EN  when defined, a missing SDRAM init-done is tolerated:
//                     after SDRAM_TMO cycles the sequence continues anyway
//                     and seqErr latches high until the next rst_n.
//                     When undefined, the sequencer waits for init-done
//                     forever and seqErr is tied low.
// ---------------------------------------------------------------------------
module reset_seq #(
  parameter int unsigned STAGE_DLY = 1024,
  parameter int unsigned SOFT_HOLD = 65536,
  parameter int unsigned SDRAM_TMO = 4194304
) (
  input  logic       clk,
  input  logic       rst_n,
  reset_seq_if.slave seqBus
);

  // One shared counter serves every timed state, so it is sized for the
  // longest of the three delays.
  localparam int unsigned MAX_AB  = (STAGE_DLY > SOFT_HOLD) ? STAGE_DLY : SOFT_HOLD;
  localparam int unsigned MAX_DLY = (MAX_AB > SDRAM_TMO) ? MAX_AB : SDRAM_TMO;
  localparam int          CNT_W   = (MAX_DLY < 2) ? 1 : $clog2(MAX_DLY + 1);

  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] STAGE_LAST = CNT_W'(STAGE_DLY - 1);
  localparam logic [CNT_W-1:0] SOFT_LAST  = CNT_W'(SOFT_HOLD - 1);
`ifdef RESET_SEQ_TMO_EN
  localparam logic [CNT_W-1:0] TMO_LAST   = CNT_W'(SDRAM_TMO - 1);
`endif

  typedef enum logic [2:0] {
    ST_SYNC    = 3'd0,
    ST_SDRAM   = 3'd1,
    ST_VIDEO_W = 3'd2,
    ST_CPU_W   = 3'd3,
    ST_RUN     = 3'd4,
    ST_SOFT    = 3'd5
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             timed;

  logic             rstMeta_q;
  logic             rstSync_q;
  logic             doneMeta_q;
  logic             doneSync_q;

  logic             sdramRstN_q;
  logic             sdramRstN_d;
  logic             videoRstN_q;
  logic             videoRstN_d;
  logic             cpuRstN_q;
  logic             cpuRstN_d;
  logic             sysReady_q;
  logic             sysReady_d;
`ifdef RESET_SEQ_TMO_EN
  logic             seqErr_q;
  logic             seqErr_d;
`endif

  // Reset deassertion synchroniser.  Assertion is immediate through the
  // async clear; release ripples through two flops so the FSM only leaves
  // SYNC two edges after rst_n rises, away from any recovery hazard.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rstMeta_q <= 1'b0;
      rstSync_q <= 1'b0;
    end else begin
      rstMeta_q <= 1'b1;
      rstSync_q <= rstMeta_q;
    end
  end

  // SDRAM init-done comes from another timing domain, so it passes through
  // a plain two-flop synchroniser before the FSM looks at it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      doneMeta_q <= 1'b0;
      doneSync_q <= 1'b0;
    end else begin
      doneMeta_q <= seqBus.sdramInitDone;
      doneSync_q <= doneMeta_q;
    end
  end

  // State and shared counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_SYNC;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Next-state logic.  Stage waits compare against DELAY-1 because the
  // counter is zero on the first cycle spent in a state, so the move happens
  // after exactly DELAY cycles there.  Soft requests are only honoured in
  // RUN; while in SOFT they are ignored, which is what makes a held request
  // re-enter SOFT one cycle after coming back to RUN.  Once SDRAM is left,
  // init-done is never looked at again, so dropping it cannot re-reset.
  always_comb begin
    state_d = state_q;
`ifdef RESET_SEQ_TMO_EN
    seqErr_d = seqErr_q;
`endif
    case (state_q)
      ST_SYNC: begin
        if (rstSync_q) begin
          state_d = ST_SDRAM;
        end
      end
      ST_SDRAM: begin
        if (doneSync_q) begin
          state_d = ST_VIDEO_W;
        end
`ifdef RESET_SEQ_TMO_EN
        else if (count_q == TMO_LAST) begin
          state_d  = ST_VIDEO_W;
          seqErr_d = 1'b1;
        end
`endif
      end
      ST_VIDEO_W: begin
        if (count_q == STAGE_LAST) begin
          state_d = ST_CPU_W;
        end
      end
      ST_CPU_W: begin
        if (count_q == STAGE_LAST) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (seqBus.softResetReq) begin
          state_d = ST_SOFT;
        end
      end
      ST_SOFT: begin
        if (count_q == SOFT_LAST) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_SYNC;
      end
    endcase
  end

  // Counter update.  Any state change restarts it at zero; in a timed state
  // it counts up and sticks at all-ones rather than wrapping, so a stalled
  // state can never alias back onto a terminal count.
  always_comb begin
    timed = 1'b0;
    case (state_q)
      ST_VIDEO_W, ST_CPU_W, ST_SOFT: timed = 1'b1;
`ifdef RESET_SEQ_TMO_EN
      ST_SDRAM:                      timed = 1'b1;
`endif
      default:                       timed = 1'b0;
    endcase

    count_d = count_q;
    if (state_d != state_q) begin
      count_d = '0;
    end else if (timed && (count_q != CNT_MAX)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // Output decode from the next state, so every reset line changes on the
  // very edge the FSM changes state.  Because the decode is monotonic along
  // the sequence, SDRAM and video resets can only fall again through rst_n.
  always_comb begin
    sdramRstN_d = (state_d != ST_SYNC);
    videoRstN_d = (state_d == ST_CPU_W) || (state_d == ST_RUN) || (state_d == ST_SOFT);
    cpuRstN_d   = (state_d == ST_RUN);
    sysReady_d  = (state_d == ST_RUN);
  end

  // Registered outputs; all forced low straight away by rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sdramRstN_q <= 1'b0;
      videoRstN_q <= 1'b0;
      cpuRstN_q   <= 1'b0;
      sysReady_q  <= 1'b0;
    end else begin
      sdramRstN_q <= sdramRstN_d;
      videoRstN_q <= videoRstN_d;
      cpuRstN_q   <= cpuRstN_d;
      sysReady_q  <= sysReady_d;
    end
  end

`ifdef RESET_SEQ_TMO_EN
  // Timeout flag is sticky: once the sequence was forced past SDRAM it stays
  // flagged until the whole subsystem is reset again.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seqErr_q <= 1'b0;
    end else begin
      seqErr_q <= seqErr_d;
    end
  end

  assign seqBus.seqErr = seqErr_q;
`else
  assign seqBus.seqErr = 1'b0;
`endif

  assign seqBus.sdramResetN = sdramRstN_q;
  assign seqBus.videoResetN = videoRstN_q;
  assign seqBus.cpuResetN   = cpuRstN_q;
  assign seqBus.sysReady    = sysReady_q;

endmodule : reset_seq

// File: tb/tb_reset_seq.sv
// ---------------------------------------------------------------------------
// tb_reset_seq
//
// Directed bench for reset_seq with STAGE_DLY=4, SOFT_HOLD=8, SDRAM_TMO=16.
// Outputs are observed as a 5-bit vector
//   {sdramResetN, videoResetN, cpuResetN, sysReady, seqErr}
// one time unit after each rising clock edge, and compared against
// hand-derived edge numbers counted from the first edge after rst_n rises.
// ---------------------------------------------------------------------------
module tb_reset_seq;

  localparam int unsigned STAGE_DLY = 4;
  localparam int unsigned SOFT_HOLD = 8;
  localparam int unsigned SDRAM_TMO = 16;

  logic clk;
  logic rst_n;
  int   checkCnt = 0;
  int   passCnt  = 0;

  reset_seq_if seqIf ();

  reset_seq #(
    .STAGE_DLY (STAGE_DLY),
    .SOFT_HOLD (SOFT_HOLD),
    .SDRAM_TMO (SDRAM_TMO)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .seqBus (seqIf.slave)
  );

  // Free-running 100 MHz-style clock; period value is irrelevant to checks.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Snapshot of every DUT output in a fixed bit order.
  function automatic logic [4:0] outsNow();
    return {seqIf.sdramResetN, seqIf.videoResetN, seqIf.cpuResetN,
            seqIf.sysReady, seqIf.seqErr};
  endfunction

  // Expected outputs on edge e of a clean power-up with init-done already
  // high: SDRAM at edge 2, video at edge 7, CPU and ready at edge 11.
  function automatic logic [4:0] expPwr(input int e);
    return {(e >= 2), (e >= 7), (e >= 11), (e >= 11), 1'b0};
  endfunction

  // Single comparison point: counts, and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [4:0] observed,
                             input logic [4:0] expected);
    checkCnt++;
    if (observed === expected) begin
      passCnt++;
    end else begin
      $display("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
    end
  endtask

  // Drive all inputs at once.
  task automatic applyStimulus(input logic rstN, input logic done, input logic req);
    rst_n                 = rstN;
    seqIf.sdramInitDone   = done;
    seqIf.softResetReq    = req;
  endtask

  // Advance to one time unit past the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Release rst_n and check edges 0..lastEdge against the power-up timeline.
  task automatic runPowerUp(input int lastEdge, input string prefix);
    rst_n = 1'b1;
    for (int e = 0; e <= lastEdge; e++) begin
      tick();
      checkOutput($sformatf("%s e%0d", prefix, e), outsNow(), expPwr(e));
    end
  endtask

  // One-cycle rst_n pulse: outputs must drop before any clock edge and stay
  // low across the edge inside the pulse.
  task automatic pulseReset(input string prefix);
    rst_n = 1'b0;
    #2;
    checkOutput({prefix, " async"}, outsNow(), 5'b00000);
    tick();
    checkOutput({prefix, " held"}, outsNow(), 5'b00000);
  endtask

  initial begin
    applyStimulus(1'b0, 1'b1, 1'b0);
    repeat (3) tick();
    checkOutput("reset hold", outsNow(), 5'b00000);

    // Power-up ordering.
    runPowerUp(12, "pwr");

    // One-cycle soft request: CPU and ready low for exactly 8 edges.
    seqIf.softResetReq = 1'b1;
    for (int i = 0; i <= 8; i++) begin
      tick();
      if (i == 0) seqIf.softResetReq = 1'b0;
      checkOutput($sformatf("soft1 i%0d", i), outsNow(),
                  (i == 8) ? 5'b11110 : 5'b11000);
    end

    // Request held for 20 edges: re-entry one cycle after each return.
    seqIf.softResetReq = 1'b1;
    for (int i = 0; i <= 27; i++) begin
      tick();
      if (i == 19) seqIf.softResetReq = 1'b0;
      checkOutput($sformatf("softHeld i%0d", i), outsNow(),
                  ((i == 8) || (i == 17) || (i >= 26)) ? 5'b11110 : 5'b11000);
    end

    // Init-done dropping while running must change nothing.
    seqIf.sdramInitDone = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      checkOutput($sformatf("doneDrop i%0d", i), outsNow(), 5'b11110);
    end
    seqIf.sdramInitDone = 1'b1;

    // Reset pulse while in CPU_W, then full replay.
    pulseReset("pre");
    runPowerUp(9, "toCpuW");
    pulseReset("rstCpuW");
    runPowerUp(12, "replayA");

    // Reset pulse while in SOFT, then full replay.
    seqIf.softResetReq = 1'b1;
    tick();
    seqIf.softResetReq = 1'b0;
    checkOutput("enterSoft", outsNow(), 5'b11000);
    repeat (3) tick();
    pulseReset("rstSoft");
    runPowerUp(12, "replayB");

`ifdef RESET_SEQ_TMO_EN
    // Init-done never arrives: forced on 16 cycles after SDRAM release.
    seqIf.sdramInitDone = 1'b0;
    pulseReset("tmoPre");
    rst_n = 1'b1;
    for (int e = 0; e <= 27; e++) begin
      tick();
      checkOutput($sformatf("tmo e%0d", e), outsNow(),
                  {(e >= 2), (e >= 22), (e >= 26), (e >= 26), (e >= 18)});
    end
    pulseReset("tmoClear");
`else
    // Init-done never arrives: video stays in reset indefinitely.
    seqIf.sdramInitDone = 1'b0;
    pulseReset("hangPre");
    rst_n = 1'b1;
    for (int e = 0; e <= 10002; e++) begin
      tick();
      checkOutput($sformatf("hang e%0d", e), outsNow(), {(e >= 2), 4'b0000});
    end

    // Init-done raised 100 cycles after SDRAM release (right after edge 102):
    // video follows 2+1+4 edges later, CPU another 4 edges on.
    pulseReset("latePre");
    rst_n = 1'b1;
    for (int e = 0; e <= 115; e++) begin
      tick();
      if (e == 102) seqIf.sdramInitDone = 1'b1;
      checkOutput($sformatf("late e%0d", e), outsNow(),
                  {(e >= 2), (e >= 109), (e >= 113), (e >= 113), 1'b0});
    end
`endif

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule : tb_reset_seq
